branch_jump_decision: RTL and testbench

- Execute-stage resolver for control-transfer instructions in the RV32I pipeline.
- Evaluates conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) and unconditional jumps (JAL/JALR) from operands, opcode, funct3, PC and the decoded immediate.
- Drives a same-cycle flush request and redirect target to fetch/decode.
- Decision path is purely combinational. Clock and reset serve only the optional statistics logic.

---
 rtl/rv32_pkg.sv | 30 +++
 rtl/branch_compare.sv | 36 +++
 rtl/branch_jump_decision.sv | 91 +++++++++
 tb/tb_branch_jump_decision.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I constants for the execute-stage control-transfer resolver.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    // Kind of redirect selected for the instruction in execute.
    typedef enum logic [1:0] {
        XFER_NONE  = 2'd0,  // no control transfer
        XFER_PCREL = 2'd1,  // taken branch or JAL: pc + imm
        XFER_REG   = 2'd2   // JALR: (rs1 + imm) with bit 0 cleared
    } xfer_e;

    // Opcodes that count as control-transfer instructions.
    function automatic logic is_ctrl_opc(input logic [6:0] opc);
        return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Conditional-branch comparator: one shared eq / signed-lt / unsigned-lt
// set, selected by funct3. Reserved funct3 encodings never report true.
module branch_compare
    import rv32_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] rs1_i,
    input  logic [W-1:0] rs2_i,
    input  logic [2:0]   func3_i,
    output logic         cond_o
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (rs1_i == rs2_i);
    assign lt  = ($signed(rs1_i) < $signed(rs2_i));
    assign ltu = (rs1_i < rs2_i);

    // Pick the relation named by funct3; GE forms are negated LT forms.
    always_comb begin
        cond_o = 1'b0;
        unique case (func3_i)
            F3_BEQ:  cond_o = eq;
            F3_BNE:  cond_o = ~eq;
            F3_BLT:  cond_o = lt;
            F3_BGE:  cond_o = ~lt;
            F3_BLTU: cond_o = ltu;
            F3_BGEU: cond_o = ~ltu;
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_jump_decision.sv
// Execute-stage branch/jump resolver. Decision and redirect target are
// purely combinational. Optional statistics counters are enabled with the
// macro BRANCH_JUMP_DECISION_STATS_EN; without it clk/rst are unused.
module branch_jump_decision
    import rv32_pkg::*;
#(
    parameter int XLEN = rv32_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] is_rs1_data,
    input  logic [XLEN-1:0] is_rs2_data,
    input  logic [6:0]      is_opcode,
    input  logic [XLEN-1:0] is_pc,
    input  logic [2:0]      is_func3,
    input  logic [XLEN-1:0] i_imm,
`ifdef BRANCH_JUMP_DECISION_STATS_EN
    output logic [31:0]     o_taken_cnt,
    output logic [31:0]     o_branch_cnt,
`endif
    output logic            branch_flush,
    output logic [XLEN-1:0] branch_pc
);

    logic            cond_true;
    xfer_e           xfer;
    logic [XLEN-1:0] pcrel_tgt;
    logic [XLEN-1:0] reg_tgt;

    branch_compare #(.W(XLEN)) u_cmp (
        .rs1_i   (is_rs1_data),
        .rs2_i   (is_rs2_data),
        .func3_i (is_func3),
        .cond_o  (cond_true)
    );

    // Both adders wrap modulo 2^XLEN; JALR clears bit 0 only.
    assign pcrel_tgt = is_pc + i_imm;
    assign reg_tgt   = (is_rs1_data + i_imm) & ~{{(XLEN-1){1'b0}}, 1'b1};

    // Classify the instruction into the redirect kind it requests.
    always_comb begin
        xfer = XFER_NONE;
        unique case (is_opcode)
            OPC_BRANCH: xfer = cond_true ? XFER_PCREL : XFER_NONE;
            OPC_JAL:    xfer = XFER_PCREL;
            OPC_JALR:   xfer = (is_func3 == F3_JALR) ? XFER_REG : XFER_NONE;
            default:    xfer = XFER_NONE;
        endcase
    end

    // Target is forced to zero when not taken so no stale address leaks.
    always_comb begin
        branch_flush = (xfer != XFER_NONE);
        branch_pc    = '0;
        unique case (xfer)
            XFER_PCREL: branch_pc = pcrel_tgt;
            XFER_REG:   branch_pc = reg_tgt;
            default:    branch_pc = '0;
        endcase
    end

`ifdef BRANCH_JUMP_DECISION_STATS_EN
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] branch_cnt_q, branch_cnt_d;

    // Next counts: bump on taken transfers / any control-transfer opcode.
    always_comb begin
        taken_cnt_d  = taken_cnt_q  + {31'd0, branch_flush};
        branch_cnt_d = branch_cnt_q + {31'd0, is_ctrl_opc(is_opcode)};
    end

    // Counter registers; reset wins over increment, natural 32-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q  <= '0;
            branch_cnt_q <= '0;
        end else begin
            taken_cnt_q  <= taken_cnt_d;
            branch_cnt_q <= branch_cnt_d;
        end
    end

    assign o_taken_cnt  = taken_cnt_q;
    assign o_branch_cnt = branch_cnt_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
`endif

endmodule

// File: tb/tb_branch_jump_decision.sv
// Self-checking bench for branch_jump_decision: directed vectors plus
// random stimulus, expected results queued by a reference model and popped
// by an independent monitor on the falling clock edge.
module tb_branch_jump_decision;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rs1, rs2, pc, imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        flush;
    logic [31:0] tgt;
`ifdef BRANCH_JUMP_DECISION_STATS_EN
    logic [31:0] taken_cnt, br_cnt;
    int unsigned m_taken, m_br;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        flush;
        logic [31:0] pc;
        logic [31:0] tag;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    branch_jump_decision dut (
        .clk          (clk),
        .rst          (rst),
        .is_rs1_data  (rs1),
        .is_rs2_data  (rs2),
        .is_opcode    (opc),
        .is_pc        (pc),
        .is_func3     (f3),
        .i_imm        (imm),
`ifdef BRANCH_JUMP_DECISION_STATS_EN
        .o_taken_cnt  (taken_cnt),
        .o_branch_cnt (br_cnt),
`endif
        .branch_flush (flush),
        .branch_pc    (tgt)
    );

    // Reference: taken/target straight from the ISA rules.
    function automatic logic ref_taken(input logic [6:0] o, input logic [2:0] f,
                                       input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 7'b1101111) return 1'b1;
        if (o == 7'b1100111) return (f == 3'd0);
        if (o != 7'b1100011) return 1'b0;
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return longint'(a) < longint'(b);
            3'd7: return longint'(a) >= longint'(b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic [6:0] o, input logic [2:0] f,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] p, input logic [31:0] i);
        longint unsigned s;
        if (!ref_taken(o, f, a, b)) return 32'h0;
        if (o == 7'b1100111) begin
            s = (longint'(a) + longint'(i)) % 64'h1_0000_0000;
            return 32'(s - (s % 2));
        end
        s = (longint'(p) + longint'(i)) % 64'h1_0000_0000;
        return 32'(s);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one instruction after the rising edge and queue its expectation.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [6:0] o,
                         input logic [2:0] f, input logic [31:0] p, input logic [31:0] i,
                         input logic [31:0] tag);
        exp_t e;
        @(posedge clk);
        #1;
        rs1 = a; rs2 = b; opc = o; f3 = f; pc = p; imm = i;
        e.flush = ref_taken(o, f, a, b);
        e.pc    = ref_target(o, f, a, b, p, i);
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the presented outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("flush#%0d", e.tag), {31'd0, flush}, {31'd0, e.flush});
                check($sformatf("target#%0d", e.tag), tgt, e.pc);
            end
`ifdef BRANCH_JUMP_DECISION_STATS_EN
            check("taken_cnt", taken_cnt, m_taken);
            check("branch_cnt", br_cnt, m_br);
`endif
        end
    end

`ifdef BRANCH_JUMP_DECISION_STATS_EN
    // Counter model sampled on the same edge the DUT uses.
    always @(posedge clk) begin
        if (rst) begin
            m_taken = 0;
            m_br    = 0;
        end else begin
            if (ref_taken(opc, f3, rs1, rs2)) m_taken = m_taken + 1;
            if (opc == 7'b1100011 || opc == 7'b1101111 || opc == 7'b1100111) m_br = m_br + 1;
        end
    end
`endif

    localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111;

    initial begin
        logic [6:0] o;
        logic [31:0] a, b;
        int wait_cyc;
        rst = 1'b1; rs1 = '0; rs2 = '0; opc = '0; f3 = '0; pc = '0; imm = '0;
        apply(0, 0, 7'h00, 0, 0, 0, 0);
        apply(32'h1234, 32'h1234, 7'h13, 0, 32'h40, 32'h10, 1);
        #1 rst = 1'b0;

        apply(32'hFFFF0000, 32'hF1F2F3F4, BR, 3'b000, 0, 8, 10);
        apply(32'hFFFF0000, 32'hFFFF0000, BR, 3'b000, 0, 8, 11);
        apply(32'hF1F2F3F4, 32'hF1F2F3F4, BR, 3'b001, 0, 8, 12);
        apply(32'hF1F2F3F4, 32'hF1F2F3F5, BR, 3'b001, 0, 8, 13);
        apply(32'h80000003, 32'h80000004, BR, 3'b100, 0, 8, 14);
        apply(32'h2, 32'h3, BR, 3'b101, 0, 8, 15);
        apply(32'h80000000, 32'h1, BR, 3'b110, 0, 8, 16);
        apply(32'h80000000, 32'h1, BR, 3'b100, 0, 8, 17);
        apply(32'h11111115, 32'h11111114, BR, 3'b111, 0, 8, 18);
        apply(32'h11111114, 32'h11111114, BR, 3'b111, 0, 8, 19);
        apply(32'hDEAD, 32'hBEEF, JL, 3'b000, 0, 8, 20);
        apply(32'h00001003, 0, JR, 3'b000, 0, 4, 21);
        apply(0, 0, JL, 3'b000, 32'hFFFFFFFC, 8, 22);
        apply(5, 5, BR, 3'b010, 0, 8, 23);
        apply(5, 5, BR, 3'b011, 0, 8, 24);
        apply(5, 5, 7'b0110011, 3'b000, 32'h100, 8, 25);
        apply(32'h1000, 0, JR, 3'b001, 0, 4, 26);
        apply(0, 0, BR, 3'b000, 32'h1000, 32'hFFFFFFF0, 27);
        apply(0, 0, BR, 3'b000, 32'h1000, 32'h6, 28);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0, 1: o = BR;
                2:    o = JL;
                3:    o = JR;
                default: o = 7'($urandom);
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 5) == 0) b = a + 32'($urandom_range(0, 2)) - 1;
            apply(a, b, o, 3'($urandom), $urandom, $urandom, 100 + n);
        end

`ifdef BRANCH_JUMP_DECISION_STATS_EN
        apply(0, 0, 7'h00, 0, 0, 0, 600);
        #1 rst = 1'b1;
        apply(0, 0, 7'h00, 0, 0, 0, 601);
        #1 rst = 1'b0;
        apply(0, 0, JL, 0, 0, 8, 602);
        apply(0, 0, JL, 0, 0, 8, 603);
        apply(0, 0, JL, 0, 0, 8, 604);
        apply(0, 0, 7'h00, 0, 0, 0, 605);
        @(negedge clk); #1;
        check("taken_after_3", taken_cnt, 32'd3);
        rst = 1'b1;
        @(negedge clk); #1;
        check("taken_after_rst", taken_cnt, 32'd0);
        check("branch_after_rst", br_cnt, 32'd0);
        rst = 1'b0;
`endif

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
